// File: rtl/dram_sp_arb.sv
// Two-requester round-robin arbiter/sequencer for a single-port LUT RAM (sync write, comb read).
// Define DRAM_ARB_CLR_EN to zero-fill the RAM after reset before any grant is issued.
module dram_sp_arb #(
  parameter int DW = 1,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_ad,
  input  logic [DW-1:0] m0_di,
  output logic          m0_gnt,
  output logic          m0_rvld,
  output logic [DW-1:0] m0_do,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_ad,
  input  logic [DW-1:0] m1_di,
  output logic          m1_gnt,
  output logic          m1_rvld,
  output logic [DW-1:0] m1_do,
  output logic [AW-1:0] ram_ad,
  output logic [DW-1:0] ram_di,
  output logic          ram_wre,
  input  logic [DW-1:0] ram_dout,
  output logic          busy
);

`ifdef DRAM_ARB_CLR_EN
  typedef enum logic {CLR, RUN} state_t;
  state_t        state;
  logic [AW-1:0] cnt;
`endif

  logic          rr;
  logic          cmd_v;
  logic          cmd_we;
  logic          cmd_who;
  logic [AW-1:0] cmd_ad;
  logic [DW-1:0] cmd_di;

  logic el0, el1, pick1, running;

  // A requester whose gnt is already high is masked so a held req is not issued twice.
  assign el0   = m0_req & ~m0_gnt;
  assign el1   = m1_req & ~m1_gnt;
  assign pick1 = el1 & (~el0 | ~rr);

`ifdef DRAM_ARB_CLR_EN
  assign running = (state == RUN);
`else
  assign running = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
`ifdef DRAM_ARB_CLR_EN
      state   <= CLR;
      cnt     <= '0;
`endif
      rr      <= 1'b1;
      cmd_v   <= 1'b0;
      cmd_we  <= 1'b0;
      cmd_who <= 1'b0;
      cmd_ad  <= '0;
      cmd_di  <= '0;
      m0_gnt  <= 1'b0;
      m1_gnt  <= 1'b0;
      m0_rvld <= 1'b0;
      m1_rvld <= 1'b0;
      m0_do   <= '0;
      m1_do   <= '0;
    end else begin
      // Stage p1: retire the command issued on the previous edge.
      m0_rvld <= 1'b0;
      m1_rvld <= 1'b0;
      if (cmd_v && !cmd_we) begin
        if (cmd_who) begin
          m1_do   <= ram_dout;
          m1_rvld <= 1'b1;
        end else begin
          m0_do   <= ram_dout;
          m0_rvld <= 1'b1;
        end
      end

`ifdef DRAM_ARB_CLR_EN
      if (state == CLR) begin
        cnt <= cnt + 1'b1;
        if (cnt == {AW{1'b1}})
          state <= RUN;
      end
`endif

      // Stage p0: arbitrate and latch the winning command.
      if (running && (el0 || el1)) begin
        cmd_v   <= 1'b1;
        cmd_who <= pick1;
        cmd_we  <= pick1 ? m1_we : m0_we;
        cmd_ad  <= pick1 ? m1_ad : m0_ad;
        cmd_di  <= pick1 ? m1_di : m0_di;
        m0_gnt  <= ~pick1;
        m1_gnt  <= pick1;
        rr      <= pick1;
      end else begin
        cmd_v   <= 1'b0;
        m0_gnt  <= 1'b0;
        m1_gnt  <= 1'b0;
      end
    end
  end

  // RAM drive comes straight from registered state; rst_n gates the write strobe.
  always_comb begin
    busy    = 1'b0;
    ram_ad  = cmd_ad;
    ram_di  = cmd_di;
    ram_wre = rst_n & cmd_v & cmd_we;
`ifdef DRAM_ARB_CLR_EN
    if (state == CLR) begin
      busy    = rst_n;
      ram_ad  = cnt;
      ram_di  = '0;
      ram_wre = rst_n;
    end
`endif
  end

endmodule

// File: tb/tb_dram_sp_arb.sv
// Directed bench for dram_sp_arb (DW=8, AW=4) with a behavioural LUT-RAM model attached.
// Builds with or without DRAM_ARB_CLR_EN; the clear-sequence checks follow the macro.
module tb_dram_sp_arb;
  localparam int DW = 8;
  localparam int AW = 4;
`ifdef DRAM_ARB_CLR_EN
  localparam logic [DW-1:0] INIT = 8'hEE;
`else
  localparam logic [DW-1:0] INIT = 8'h00;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0] m0_ad, m1_ad;
  logic [DW-1:0] m0_di, m1_di;
  logic          m0_gnt, m0_rvld, m1_gnt, m1_rvld;
  logic [DW-1:0] m0_do, m1_do;
  logic [AW-1:0] ram_ad;
  logic [DW-1:0] ram_di, ram_dout;
  logic          ram_wre, busy;

  logic [DW-1:0] mem [2**AW];
  logic          init_done = 1'b0;

  int n_vec = 0;
  int n_bad = 0;

  dram_sp_arb #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_ad(m0_ad), .m0_di(m0_di),
    .m0_gnt(m0_gnt), .m0_rvld(m0_rvld), .m0_do(m0_do),
    .m1_req(m1_req), .m1_we(m1_we), .m1_ad(m1_ad), .m1_di(m1_di),
    .m1_gnt(m1_gnt), .m1_rvld(m1_rvld), .m1_do(m1_do),
    .ram_ad(ram_ad), .ram_di(ram_di), .ram_wre(ram_wre),
    .ram_dout(ram_dout), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 2**AW; i++) mem[i] <= INIT;
      init_done <= 1'b1;
    end else if (ram_wre) begin
      mem[ram_ad] <= ram_di;
    end
  end
  assign ram_dout = mem[ram_ad];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    m0_req = 1'b0; m0_we = 1'b0; m0_ad = '0; m0_di = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_ad = '0; m1_di = '0;
    repeat (3) tick();

    chk("rst_m0_gnt", m0_gnt, 0);
    chk("rst_m1_gnt", m1_gnt, 0);
    chk("rst_m0_rvld", m0_rvld, 0);
    chk("rst_m1_rvld", m1_rvld, 0);
    chk("rst_m0_do", m0_do, 0);
    chk("rst_m1_do", m1_do, 0);
    chk("rst_ram_ad", ram_ad, 0);
    chk("rst_ram_di", ram_di, 0);
    chk("rst_ram_wre", ram_wre, 0);
    chk("rst_busy", busy, 0);

    // m1 requests a read of address 5 from the moment reset is released
    rst_n = 1'b1;
    m1_req = 1'b1; m1_we = 1'b0; m1_ad = 4'd5;
`ifdef DRAM_ARB_CLR_EN
    for (int i = 0; i < 16; i++) begin
      chk("clr_busy", busy, 1);
      chk("clr_wre", ram_wre, 1);
      chk("clr_ad", ram_ad, i);
      chk("clr_di", ram_di, 0);
      chk("clr_m1_gnt", m1_gnt, 0);
      tick();
    end
    chk("clr_done_busy", busy, 0);
    chk("clr_done_wre", ram_wre, 0);
`else
    chk("run_busy", busy, 0);
`endif
    chk("pre_m1_gnt", m1_gnt, 0);
    tick();
    chk("first_m1_gnt", m1_gnt, 1);
    chk("first_m0_gnt", m0_gnt, 0);
    m1_req = 1'b0;
    tick();
    chk("first_m1_rvld", m1_rvld, 1);
    chk("first_m1_do", m1_do, 8'h00);
    chk("first_m1_gnt_off", m1_gnt, 0);

    // m0 writes 0xA5 to address 3, then reads it back
    m0_req = 1'b1; m0_we = 1'b1; m0_ad = 4'd3; m0_di = 8'hA5;
    tick();
    chk("wr_m0_gnt", m0_gnt, 1);
    chk("wr_m1_gnt", m1_gnt, 0);
    chk("wr_ram_wre", ram_wre, 1);
    chk("wr_ram_ad", ram_ad, 3);
    chk("wr_ram_di", ram_di, 8'hA5);
    m0_req = 1'b0;
    tick();
    chk("wr_m0_gnt_off", m0_gnt, 0);
    chk("wr_no_rvld", m0_rvld, 0);
    chk("wr_do_hold", m0_do, 0);
    chk("wr_wre_off", ram_wre, 0);
    m0_req = 1'b1; m0_we = 1'b0; m0_ad = 4'd3;
    tick();
    chk("rd_m0_gnt", m0_gnt, 1);
    chk("rd_ram_wre", ram_wre, 0);
    chk("rd_ram_ad", ram_ad, 3);
    m0_req = 1'b0;
    tick();
    chk("rd_m0_rvld", m0_rvld, 1);
    chk("rd_m0_do", m0_do, 8'hA5);
    chk("rd_m1_rvld", m1_rvld, 0);
    chk("rd_m1_gnt", m1_gnt, 0);
    tick();
    chk("rd_rvld_pulse", m0_rvld, 0);
    chk("rd_do_hold", m0_do, 8'hA5);

    // m0 writes 0x3C to address 7; m1 reads address 7 on the very next grant
    m0_req = 1'b1; m0_we = 1'b1; m0_ad = 4'd7; m0_di = 8'h3C;
    tick();
    chk("x_m0_gnt", m0_gnt, 1);
    m0_req = 1'b0;
    m1_req = 1'b1; m1_we = 1'b0; m1_ad = 4'd7;
    tick();
    chk("x_m1_gnt", m1_gnt, 1);
    chk("x_m0_gnt_off", m0_gnt, 0);
    m1_req = 1'b0;
    tick();
    chk("x_m1_rvld", m1_rvld, 1);
    chk("x_m1_do", m1_do, 8'h3C);

    // both masters read continuously; grants alternate starting with m0
    m0_req = 1'b1; m0_we = 1'b0; m0_ad = 4'd3;
    m1_req = 1'b1; m1_we = 1'b0; m1_ad = 4'd7;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("cont_m0_gnt", m0_gnt, (k % 2 == 0));
      chk("cont_m1_gnt", m1_gnt, (k % 2 == 1));
      chk("cont_m0_rvld", m0_rvld, (k % 2 == 1));
      chk("cont_m1_rvld", m1_rvld, (k > 0) && (k % 2 == 0));
    end
    chk("cont_m0_do", m0_do, 8'hA5);
    chk("cont_m1_do", m1_do, 8'h3C);
    m0_req = 1'b0; m1_req = 1'b0;
    repeat (2) tick();

    // reset lands while a read grant is showing
    m0_req = 1'b1; m0_we = 1'b0; m0_ad = 4'd3;
    tick();
    chk("mid_m0_gnt", m0_gnt, 1);
    rst_n = 1'b0;
    m0_req = 1'b0;
    chk("mid_wre_forced", ram_wre, 0);
    tick();
    chk("mid_m0_rvld", m0_rvld, 0);
    chk("mid_m0_gnt_off", m0_gnt, 0);
    chk("mid_m0_do", m0_do, 0);
    chk("mid_m1_do", m1_do, 0);
    chk("mid_ram_wre", ram_wre, 0);
    chk("mid_ram_ad", ram_ad, 0);
    chk("mid_busy", busy, 0);
    tick();
    rst_n = 1'b1;
`ifdef DRAM_ARB_CLR_EN
    chk("reclr_busy", busy, 1);
    chk("reclr_ad", ram_ad, 0);
    chk("reclr_wre", ram_wre, 1);
    repeat (16) tick();
    chk("reclr_done", busy, 0);
`else
    chk("rerun_busy", busy, 0);
    chk("rerun_wre", ram_wre, 0);
`endif

    // a lone continuous requester is granted every other cycle
    m0_req = 1'b1; m0_we = 1'b0; m0_ad = 4'd3;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("solo_m0_gnt", m0_gnt, (k % 2 == 0));
      chk("solo_m0_rvld", m0_rvld, (k % 2 == 1));
      chk("solo_m1_gnt", m1_gnt, 0);
    end
    m0_req = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dram_sp_arb.md
Name: dram_sp_arb

Overview:
- Two-requester round-robin arbiter and sequencer in front of one single-port distributed RAM (RAM16S-style LUT RAM: synchronous write, combinational read).
- Each requester issues read or write commands over a req/gnt handshake. The block drives the RAM address, data and write-enable from registered command state, and returns read data one cycle after grant.
- Optionally clears the whole RAM to zero after reset before accepting traffic.

Parameters:
- DW, 1, data width of RAM word and requester data buses
- AW, 4, address width; RAM depth = 2^AW

Ports:
- clk  in  1  single clock; all logic rising-edge
- rst_n  in  1  reset, synchronous, active-low
- m0_req  in  1  requester 0 command valid; held until gnt sampled
- m0_we  in  1  requester 0: 1=write, 0=read
- m0_ad  in  AW  requester 0 address
- m0_di  in  DW  requester 0 write data
- m0_gnt  out  1  requester 0 command accepted (one-cycle pulse)
- m0_rvld  out  1  requester 0 read data valid (one-cycle pulse)
- m0_do  out  DW  requester 0 read data; holds last read value
- m1_req, m1_we, m1_ad, m1_di, m1_gnt, m1_rvld, m1_do  same as m0_*, for requester 1
- ram_ad  out  AW  RAM address
- ram_di  out  DW  RAM write data
- ram_wre  out  1  RAM write enable
- ram_dout  in  DW  RAM combinational read data
- busy  out  1  high while clearing; no grants issued

Behaviour:
- Reset (rst_n=0 at an edge): all outputs 0, including m*_gnt, m*_rvld, m*_do, ram_ad, ram_di, ram_wre and busy.
  - State goes to CLR (with DRAM_ARB_CLR_EN) or RUN (without).
  - rr pointer = 1, so requester 0 wins the first tie. cmd_v = 0, clear counter = 0.
- ram_wre is forced 0 while rst_n=0. Assertion of rst_n mid-operation drops any in-flight command and rvld; RAM contents are not guaranteed.
- States: CLR, RUN.
- CLR:
  - ram_ad = counter, ram_di = 0, ram_wre = 1, busy = 1. Counter increments each cycle.
  - After the write at address 2^AW-1, go to RUN. Lasts exactly 2^AW cycles.
  - Requests are ignored, not lost: requesters keep req high.
- RUN, issue at edge E0:
  - Eligible requester: req=1 and its own gnt not currently high. This masking prevents double issue while the requester updates req on the same edge it samples gnt.
  - Neither eligible: cmd_v <= 0.
  - One eligible: it wins.
  - Both eligible: the requester other than the rr pointer wins.
  - Winner's we/ad/di are latched into the command registers. cmd_v <= 1, winner gnt <= 1 (other 0), rr pointer <= winner.
- Cycle E0..E1:
  - ram_ad = cmd_ad, ram_di = cmd_di, ram_wre = cmd_v & cmd_we.
  - A write commits at E1.
  - A read: at E1 ram_dout is latched into winner's m*_do and m*_rvld <= 1 for one cycle.
- Latency:
  - gnt is 1 cycle after req is sampled.
  - Read data/rvld is 2 edges after req is sampled.
  - Write is visible to a command issued at the next edge.
- Throughput: one command per cycle total. A single continuously requesting master gets every other cycle; two continuous masters alternate every cycle.
- Ordering: a write granted at E0 followed by a read of the same address granted at E1 (either master) returns the new data.
- m*_rvld never asserts for writes. m*_do unchanged on writes.
- busy = (state==CLR).

Optional Feature:
- Macro DRAM_ARB_CLR_EN.
- Defined: the post-reset CLR sequence above (2^AW zero writes, busy high).
- Undefined: the CLR state and counter are absent. The block enters RUN on the first edge with rst_n=1, busy is tied 0, and RAM initial contents are undefined.

Test Plan:
- CLR (macro defined, AW=4, DW=8): release rst_n -> busy=1 and ram_wre=1 for 16 cycles, ram_ad 0..15, ram_di=0; then busy=0; subsequent reads of any address return 0x00.
- Single write/read: m0 write ad=3 di=0xA5, then m0 read ad=3 -> m0_gnt one cycle after each req sample; m0_rvld pulses 2 edges after read req with m0_do=0xA5; m1_* stay 0.
- Contention: m0 and m1 both read continuously after reset/CLR -> grants alternate m0,m1,m0,m1; first tie goes to m0; never both gnt in one cycle.
- Write-then-read cross master: m0 write ad=7 di=0x3C granted at E0, m1 read ad=7 granted at E1 -> m1_do=0x3C with m1_rvld.
- Requests during CLR: m1_req high from reset release -> no m1_gnt until busy falls; first m1_gnt the cycle after busy=0.
- Reset mid-operation: assert rst_n=0 the cycle m0_gnt is high for a read -> next cycle m0_rvld=0, ram_wre=0, all outputs 0; CLR restarts from address 0 on release.
